// File: rtl/tank_tune_if.sv
// Bundle of the sweep controls, the ADC envelope stream and the cap-bank outputs.
// The master side drives the controls and samples; the slave side is the sequencer.
interface tank_tune_if #(
    parameter int CODE_W = 5,
    parameter int AMP_W  = 12
);
    logic              start;
    logic              abort;
    logic              amp_valid;
    logic [AMP_W-1:0]  amp_sample;
    logic [CODE_W-1:0] cap_code;
    logic              busy;
    logic              done;
    logic              err;
    logic [CODE_W-1:0] best_code;
    logic [AMP_W-1:0]  best_amp;

    modport master (
        output start,
        output abort,
        output amp_valid,
        output amp_sample,
        input  cap_code,
        input  busy,
        input  done,
        input  err,
        input  best_code,
        input  best_amp
    );

    modport slave (
        input  start,
        input  abort,
        input  amp_valid,
        input  amp_sample,
        output cap_code,
        output busy,
        output done,
        output err,
        output best_code,
        output best_amp
    );
endinterface

// File: rtl/tank_tune_ctrl.sv
// LC-tank calibration sequencer: sweeps every cap-bank code, settles, takes the
// peak envelope over a window of ADC samples and applies the code of maximum gain.
module tank_tune_ctrl #(
    parameter int CODE_W     = 5,
    parameter int AMP_W      = 12,
    parameter int SETTLE_CYC = 1000,
    parameter int MEAS_LOG2  = 6,
    parameter int MIN_AMP    = 64,
    parameter int RESET_CODE = 16
) (
    input  logic      clk,
    input  logic      rst,
    tank_tune_if.slave tt
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int SMP_W = MEAS_LOG2 + 1;

    localparam logic [SET_W-1:0]  SET_INIT = SET_W'(SETTLE_CYC);
    localparam logic [SET_W-1:0]  SET_ONE  = SET_W'(1);
    localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'((1 << MEAS_LOG2) - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [CODE_W-1:0] RST_CODE = CODE_W'(RESET_CODE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_APPLY
    } state_t;

    state_t            state_q,     state_d;
    logic [CODE_W-1:0] code_q,      code_d;
    logic [CODE_W-1:0] save_q,      save_d;
    logic [CODE_W-1:0] best_code_q, best_code_d;
    logic [AMP_W-1:0]  best_amp_q,  best_amp_d;
    logic [AMP_W-1:0]  peak_q,      peak_d;
    logic [SET_W-1:0]  settle_q,    settle_d;
    logic [SMP_W-1:0]  smp_q,       smp_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;

    // Next-state and next-output logic; abort overrides every busy transition.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        save_d      = save_q;
        best_code_d = best_code_q;
        best_amp_d  = best_amp_q;
        peak_d      = peak_q;
        settle_d    = settle_q;
        smp_d       = smp_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (tt.start) begin
                    state_d     = S_SETTLE;
                    save_d      = code_q;
                    code_d      = '0;
                    best_amp_d  = '0;
                    best_code_d = '0;
                    err_d       = 1'b0;
                    settle_d    = SET_INIT;
                    busy_d      = 1'b1;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q - SET_ONE;
                if (settle_q == SET_ONE) begin
                    state_d = S_MEASURE;
                    peak_d  = '0;
                    smp_d   = '0;
                end
            end
            S_MEASURE: begin
                if (tt.amp_valid) begin
                    if (tt.amp_sample > peak_q) begin
                        peak_d = tt.amp_sample;
                    end
                    smp_d = smp_q + SMP_W'(1);
                    if (smp_q == SMP_LAST) begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                // Strict compare so a tie keeps the lower code found first.
                if (peak_q > best_amp_q) begin
                    best_amp_d  = peak_q;
                    best_code_d = code_q;
                end
                if (code_q == CODE_MAX) begin
                    state_d = S_APPLY;
                end else begin
                    code_d   = code_q + CODE_W'(1);
                    settle_d = SET_INIT;
                    state_d  = S_SETTLE;
                end
            end
            S_APPLY: begin
                code_d  = best_code_q;
                err_d   = (int'(best_amp_q) < MIN_AMP);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Cancel restores the pre-sweep code and freezes the partial results.
        if (tt.abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            code_d      = save_q;
            best_code_d = best_code_q;
            best_amp_d  = best_amp_q;
            err_d       = err_q;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= RST_CODE;
            save_q      <= '0;
            best_code_q <= '0;
            best_amp_q  <= '0;
            peak_q      <= '0;
            settle_q    <= '0;
            smp_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            save_q      <= save_d;
            best_code_q <= best_code_d;
            best_amp_q  <= best_amp_d;
            peak_q      <= peak_d;
            settle_q    <= settle_d;
            smp_q       <= smp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign tt.cap_code  = code_q;
    assign tt.busy      = busy_q;
    assign tt.done      = done_q;
    assign tt.err       = err_q;
    assign tt.best_code = best_code_q;
    assign tt.best_amp  = best_amp_q;

endmodule

// File: tb/tb_tank_tune_ctrl.sv
// Bench for tank_tune_ctrl: a tank plant returns per-code sample windows and a
// reference model predicts the winning code, amplitude, error flag and timing.
module tb_tank_tune_ctrl;

    localparam int CODE_W     = 3;
    localparam int AMP_W      = 12;
    localparam int SETTLE_CYC = 4;
    localparam int MEAS_LOG2  = 2;
    localparam int MIN_AMP    = 64;
    localparam int RESET_CODE = 4;
    localparam int NCODE      = 1 << CODE_W;
    localparam int NMEAS      = 1 << MEAS_LOG2;
    localparam int LAT        = 2 + NCODE * (SETTLE_CYC + NMEAS + 1);

    logic clk = 1'b0;
    logic rst;

    tank_tune_if #(.CODE_W(CODE_W), .AMP_W(AMP_W)) tt ();

    tank_tune_ctrl #(
        .CODE_W    (CODE_W),
        .AMP_W     (AMP_W),
        .SETTLE_CYC(SETTLE_CYC),
        .MEAS_LOG2 (MEAS_LOG2),
        .MIN_AMP   (MIN_AMP),
        .RESET_CODE(RESET_CODE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tt (tt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int unsigned win [NCODE][NMEAS];
    int res_tab [NCODE] = '{10, 40, 200, 900, 300, 50, 20, 5};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_const(input int c, input int v);
        for (int k = 0; k < NMEAS; k++) win[c][k] = v;
    endtask

    task automatic load_res();
        for (int c = 0; c < NCODE; c++) set_const(c, res_tab[c]);
    endtask

    // One full sweep: plant drives the window of the current code, aligned so the
    // measured samples are win[code][0..NMEAS-1] in order when amp_valid stays high.
    task automatic run_sweep(input string tag, input bit cont, input bit poke, input bit with_abort);
        int pk [NCODE];
        int bc, ba, n, j, prev, lat;
        int q[$];
        int eq[$];
        bit busy_ok, seq_ok;
        bc = 0;
        ba = 0;
        for (int c = 0; c < NCODE; c++) begin
            pk[c] = 0;
            for (int k = 0; k < NMEAS; k++)
                if (int'(win[c][k]) > pk[c]) pk[c] = int'(win[c][k]);
            if (pk[c] > ba) begin
                ba = pk[c];
                bc = c;
            end
        end
        for (int c = 0; c < NCODE; c++) eq.push_back(c);
        if (bc != NCODE - 1) eq.push_back(bc);

        @(negedge clk);
        tt.start     = 1'b1;
        tt.abort     = with_abort;
        tt.amp_valid = 1'b1;
        n = 0;
        j = 0;
        prev = -1;
        lat = -1;
        busy_ok = 1'b1;
        while (n < 4000 && lat < 0) begin
            @(negedge clk);
            n++;
            tt.start = (poke && n == 20);
            tt.abort = 1'b0;
            if (n == 1 || int'(tt.cap_code) != prev) begin
                j = 1;
                q.push_back(int'(tt.cap_code));
            end else begin
                j++;
            end
            prev = int'(tt.cap_code);
            if (tt.done) lat = n;
            else if (!tt.busy) busy_ok = 1'b0;
            tt.amp_valid  = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
            tt.amp_sample = AMP_W'(win[tt.cap_code][(j - 1) % NMEAS]);
        end
        chk({tag, "_done_seen"}, 32'(lat > 0), 32'd1);
        if (cont) chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_seq_len"}, q.size(), eq.size());
        seq_ok = (q.size() == eq.size());
        for (int i = 0; i < q.size() && i < eq.size(); i++)
            if (q[i] != eq[i]) seq_ok = 1'b0;
        chk({tag, "_seq"}, 32'(seq_ok), 32'd1);
        chk({tag, "_cap_code"}, tt.cap_code, bc);
        chk({tag, "_best_code"}, tt.best_code, bc);
        chk({tag, "_best_amp"}, tt.best_amp, ba);
        chk({tag, "_err"}, tt.err, 32'(ba < MIN_AMP));
        chk({tag, "_busy_end"}, tt.busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, tt.done, 0);
    endtask

    initial begin
        int n;
        bit ok;
        int pat [NMEAS] = '{100, 500, 20, 7};
        tt.start      = 1'b0;
        tt.abort      = 1'b0;
        tt.amp_valid  = 1'b0;
        tt.amp_sample = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cap_code", tt.cap_code, RESET_CODE);
        chk("rst_busy", tt.busy, 0);
        chk("rst_done", tt.done, 0);
        chk("rst_err", tt.err, 0);
        chk("rst_best_code", tt.best_code, 0);
        chk("rst_best_amp", tt.best_amp, 0);

        load_res();
        run_sweep("res", 1'b1, 1'b1, 1'b0);

        for (int c = 0; c < NCODE; c++)
            for (int k = 0; k < NMEAS; k++) win[c][k] = $urandom_range(0, 499);
        for (int k = 0; k < NMEAS; k++) begin
            win[2][k] = pat[k];
            win[5][k] = pat[k];
        end
        run_sweep("tie", 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < NCODE; c++) set_const(c, 30);
        run_sweep("nosig", 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCODE; c++) begin
                if (r % 2 == 0) begin
                    for (int k = 0; k < NMEAS; k++)
                        win[c][k] = (r == 4) ? $urandom_range(0, 63) : $urandom_range(0, 4095);
                end else begin
                    set_const(c, $urandom_range(0, 4095));
                end
            end
            run_sweep("rnd", r % 2 == 0, 1'b0, r == 5);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_res();
        tt.start     = 1'b1;
        tt.amp_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            tt.start = 1'b0;
            tt.amp_sample = AMP_W'(win[tt.cap_code][0]);
            n++;
            if (tt.cap_code == 5) ok = 1'b1;
        end
        chk("abort_reach_code5", 32'(ok), 32'd1);
        tt.amp_valid = 1'b0;
        repeat (SETTLE_CYC + 2) @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tt.cap_code != 5 || !tt.busy || tt.done) ok = 1'b0;
        end
        chk("stall_hold", 32'(ok), 32'd1);
        tt.abort = 1'b1;
        @(negedge clk);
        tt.abort = 1'b0;
        chk("abort_busy", tt.busy, 0);
        chk("abort_cap_code", tt.cap_code, RESET_CODE);
        chk("abort_done", tt.done, 0);
        chk("abort_best_code", tt.best_code, 3);
        chk("abort_best_amp", tt.best_amp, 900);
        chk("abort_err", tt.err, 0);
        ok = 1'b1;
        tt.abort = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tt.done || tt.busy || tt.cap_code != RESET_CODE) ok = 1'b0;
        end
        tt.abort = 1'b0;
        chk("idle_abort_quiet", 32'(ok), 32'd1);

        tt.start     = 1'b1;
        tt.amp_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            tt.start = 1'b0;
            n++;
            if (tt.cap_code == 6) ok = 1'b1;
        end
        chk("rstmid_reach_code6", 32'(ok), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_cap_code", tt.cap_code, RESET_CODE);
        chk("rstmid_busy", tt.busy, 0);
        chk("rstmid_best_amp", tt.best_amp, 0);
        chk("rstmid_err", tt.err, 0);
        run_sweep("clean", 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tank_tune_ctrl.md
Name: tank_tune_ctrl

Overview:
- Calibration sequencer for the selective (LC-tank) amplifier stage.
- Steps the tank's switched-capacitor bank code across its full range and waits for the stage to settle at each code.
- At each code, measures output envelope amplitude as the peak over a fixed number of ADC samples, then applies the code giving maximum gain (tank centred on the carrier).
- Sits between the envelope-detector ADC interface and the cap-bank control register.

Parameters:
- CODE_W, 5, width of cap-bank code; codes 0..2^CODE_W-1 swept.
- AMP_W, 12, width of unsigned amplitude samples.
- SETTLE_CYC, 1000, cycles waited after each code change (>=1).
- MEAS_LOG2, 6, log2 of valid samples measured per code.
- MIN_AMP, 64, best amplitude below this flags err.
- RESET_CODE, 16, cap_code after reset (mid-bank).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin calibration sweep; sampled in IDLE only.
- abort  in  1  cancel sweep, restore pre-sweep code.
- amp_valid  in  1  amp_sample qualifier.
- amp_sample  in  AMP_W  unsigned envelope magnitude.
- cap_code  out  CODE_W  cap-bank code driven to tank.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on sweep completion.
- err  out  1  sticky until next start: best_amp < MIN_AMP.
- best_code  out  CODE_W  code of maximum amplitude from last sweep.
- best_amp  out  AMP_W  maximum peak found.

Behaviour:
- Reset: cap_code=RESET_CODE, busy=0, done=0, err=0, best_code=0, best_amp=0, state IDLE, counters 0.
- States: IDLE, SETTLE, MEASURE, EVAL, APPLY.
- IDLE -> SETTLE on start:
  - save_code=cap_code; cap_code=0; best_amp=0; best_code=0; err=0; settle_cnt=SETTLE_CYC.
- SETTLE: settle_cnt decrements each cycle; amp_valid ignored. Exactly SETTLE_CYC cycles in SETTLE, then MEASURE with peak=0, smp_cnt=0.
- MEASURE: on each amp_valid, peak=max(peak,amp_sample) and smp_cnt++. After the 2^MEAS_LOG2-th valid sample is accepted, go to EVAL next cycle. Stalls indefinitely without amp_valid.
- EVAL (1 cycle):
  - If peak > best_amp (strict): best_amp=peak, best_code=cap_code. Ties keep the lower code.
  - If cap_code == all-ones: go APPLY.
  - Else: cap_code+1, settle_cnt=SETTLE_CYC, go SETTLE.
- APPLY (1 cycle): cap_code=best_code; err=(best_amp<MIN_AMP); done=1 for exactly that cycle's output; go IDLE.
- All-zero amplitude: best_code=0, best_amp=0, err=1.
- Timing: with amp_valid continuously high, per-code time = SETTLE_CYC + 2^MEAS_LOG2 + 1 cycles. Total start-to-done = 2^CODE_W*(that) + 2 cycles.
- abort (any non-IDLE state): next cycle IDLE, cap_code=save_code, busy=0, no done. best_code/best_amp keep partial values; err unchanged.
  - abort has priority over all transitions including APPLY.
  - abort in IDLE has no effect.
- start while busy: ignored. start and abort both high in IDLE: start wins (abort only acts when busy).
- rst mid-sweep: all outputs to reset values; cap_code=RESET_CODE, not save_code.
- No arithmetic wrap:
  - peak and best_amp saturate naturally (max only).
  - smp_cnt is MEAS_LOG2+1 bits.
  - settle_cnt is wide enough for SETTLE_CYC.

Test Plan:
- Bench params: CODE_W=3, SETTLE_CYC=4, MEAS_LOG2=2, MIN_AMP=64, RESET_CODE=4.
- Reset: after rst, cap_code=4, busy=0, done=0, err=0, best_code=0, best_amp=0.
- Resonance sweep: amp_valid=1; model returns amplitude per cap_code {10,40,200,900,300,50,20,5}. Required: done pulses exactly 2 + 8*(4+4+1)=74 cycles after start; cap_code=3, best_code=3, best_amp=900, err=0; cap_code sequence 0..7 then 3.
- Tie and peak-within-window: codes 2 and 5 both give max 500, with samples per window {100,500,20,7}. Required: best_code=2, best_amp=500 (peak, not last sample).
- No signal: all samples 30 -> done, err=1, best_amp=30, best_code=0, cap_code=0.
- Abort and stall:
  - amp_valid low for 50 cycles in MEASURE: state holds, cap_code steady.
  - abort asserted while cap_code=5: next cycle busy=0, cap_code=4, no done.
  - start during busy: no restart.
- Reset mid-sweep: rst while cap_code=6 -> cap_code=4, busy=0. A subsequent start runs a full clean sweep.
